mem_stage: RTL and testbench

- Memory-access pipeline stage sitting between EX and WB.
- Takes one instruction at a time from the EX→MEM pipe and performs data-bus load/store on a req/ready + rvalid bus.
- Aligns and sign/zero-extends load data.
- Owns the MEM→WB pipeline register that drives every wb_pipe_* signal consumed by WB.
- CSR fields pass through unchanged.

---
 rtl/mem_stage_if.sv | 29 ++
 rtl/mem_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Data-bus interface between the memory stage and the memory system.
//   master (memory stage): drives dbus_req, dbus_write, dbus_addr,
//                          dbus_wdata, dbus_wstrb; samples dbus_ready,
//                          dbus_rvalid, dbus_rdata.
//   slave  (memory side) : the mirror image.
// A request is accepted in a cycle where dbus_req and dbus_ready are both
// high. Load data returns on dbus_rvalid at least one cycle after acceptance.
interface mem_stage_if #(
    parameter int XLEN = 32
);
    logic            dbus_req;
    logic            dbus_write;
    logic [XLEN-1:0] dbus_addr;
    logic [XLEN-1:0] dbus_wdata;
    logic [3:0]      dbus_wstrb;
    logic            dbus_ready;
    logic            dbus_rvalid;
    logic [XLEN-1:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_write, dbus_addr, dbus_wdata, dbus_wstrb,
        input  dbus_ready, dbus_rvalid, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_write, dbus_addr, dbus_wdata, dbus_wstrb,
        output dbus_ready, dbus_rvalid, dbus_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between EX and WB.
// Takes one EX->MEM entry at a time, performs a load or store on the data
// bus, aligns/extends load data and owns the MEM->WB pipeline register.
// Ports:
//   clk, rst_b            clock, asynchronous active-low reset
//   mem_pipe_*            EX->MEM entry (valid/ready handshake, flush out)
//   dbus                  data-bus master (mem_stage_if.master)
//   wb_pipe_ready/flush   backpressure and flush from WB
//   wb_pipe_*             registered MEM->WB entry
module mem_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_b,

    output logic              mem_pipe_ready,
    output logic              mem_pipe_flush,
    input  logic              mem_pipe_valid,
    input  logic [XLEN-1:0]   mem_pipe_pc,
    input  logic [XLEN-1:0]   mem_pipe_instruction,
    input  logic              mem_pipe_rd_write,
    input  logic [REG_AW-1:0] mem_pipe_rd_addr,
    input  logic [XLEN-1:0]   mem_pipe_alu_result,
    input  logic              mem_pipe_mem_read,
    input  logic              mem_pipe_mem_write,
    input  logic [2:0]        mem_pipe_mem_funct3,
    input  logic [XLEN-1:0]   mem_pipe_store_data,
    input  logic              mem_pipe_csr_write,
    input  logic              mem_pipe_csr_set,
    input  logic              mem_pipe_csr_clear,
    input  logic              mem_pipe_csr_read,
    input  logic [XLEN-1:0]   mem_pipe_csr_info,
    input  logic [11:0]       mem_pipe_csr_addr,

    mem_stage_if.master       dbus,

    input  logic              wb_pipe_ready,
    input  logic              wb_pipe_flush,
    output logic              wb_pipe_valid,
    output logic [XLEN-1:0]   wb_pipe_pc,
    output logic [XLEN-1:0]   wb_pipe_instruction,
    output logic              wb_pipe_rd_write,
    output logic [REG_AW-1:0] wb_pipe_rd_addr,
    output logic [XLEN-1:0]   wb_pipe_rd_data,
    output logic              wb_pipe_csr_write,
    output logic              wb_pipe_csr_set,
    output logic              wb_pipe_csr_clear,
    output logic              wb_pipe_csr_read,
    output logic [XLEN-1:0]   wb_pipe_csr_info,
    output logic [11:0]       wb_pipe_csr_addr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_RSP,
        S_DONE,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   instruction;
        logic              rd_write;
        logic [REG_AW-1:0] rd_addr;
        logic [XLEN-1:0]   rd_data;
        logic              csr_write;
        logic              csr_set;
        logic              csr_clear;
        logic              csr_read;
        logic [XLEN-1:0]   csr_info;
        logic [11:0]       csr_addr;
    } wb_t;

    // Replicate store data so the addressed lane always carries it.
    function automatic logic [XLEN-1:0] store_wdata(input logic [XLEN-1:0] data,
                                                    input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   store_wdata = {4{data[7:0]}};
            2'b01:   store_wdata = {2{data[15:0]}};
            default: store_wdata = data;
        endcase
    endfunction

    // Misaligned halfwords simply lose the lanes shifted past bit 3.
    function automatic logic [3:0] store_wstrb(input logic [1:0] off,
                                               input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   store_wstrb = 4'b0001 << off;
            2'b01:   store_wstrb = 4'b0011 << off;
            default: store_wstrb = 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata,
                                                    input logic [1:0] off,
                                                    input logic [2:0] f3);
        logic [XLEN-1:0] sh;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  load_extend = {{(XLEN-8){sh[7]}}, sh[7:0]};
            3'b001:  load_extend = {{(XLEN-16){sh[15]}}, sh[15:0]};
            3'b100:  load_extend = {{(XLEN-8){1'b0}}, sh[7:0]};
            3'b101:  load_extend = {{(XLEN-16){1'b0}}, sh[15:0]};
            default: load_extend = rdata;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [XLEN-1:0] load_buf_q, load_buf_d;
    logic            wb_valid_q, wb_valid_d;
    wb_t             wb_q, wb_d;

    logic is_mem;
    logic req;
    logic accepted;
    logic mem_done;
    logic wb_free;

    assign is_mem   = mem_pipe_mem_read | mem_pipe_mem_write;
    // A flush drops a request that has not been accepted yet.
    assign req      = (state_q == S_IDLE) & mem_pipe_valid & is_mem & ~wb_pipe_flush;
    assign accepted = req & dbus.dbus_ready;
    // A store accepted this cycle is complete, so it can retire immediately.
    assign mem_done = ~is_mem | (state_q == S_DONE) | (accepted & mem_pipe_mem_write);
    assign wb_free  = ~wb_valid_q | wb_pipe_ready;

    // DRAIN blocks retirement even of non-memory entries until the orphaned
    // response has been swallowed.
    assign mem_pipe_ready = mem_pipe_valid & mem_done & wb_free & ~wb_pipe_flush
                          & (state_q != S_DRAIN);
    assign mem_pipe_flush = wb_pipe_flush;

    assign dbus.dbus_req   = req;
    assign dbus.dbus_write = mem_pipe_mem_write;
    assign dbus.dbus_addr  = {mem_pipe_alu_result[XLEN-1:2], 2'b00};
    assign dbus.dbus_wdata = store_wdata(mem_pipe_store_data, mem_pipe_mem_funct3);
    assign dbus.dbus_wstrb = store_wstrb(mem_pipe_alu_result[1:0], mem_pipe_mem_funct3);

    always_comb begin
        state_d    = state_q;
        load_buf_d = load_buf_q;
        case (state_q)
            S_IDLE: begin
                if (accepted) begin
                    if (mem_pipe_mem_read) begin
                        state_d = S_WAIT_RSP;
                    end else if (!mem_pipe_ready) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WAIT_RSP: begin
                if (wb_pipe_flush) begin
                    // A response arriving with the flush is discarded here.
                    state_d = dbus.dbus_rvalid ? S_IDLE : S_DRAIN;
                end else if (dbus.dbus_rvalid) begin
                    load_buf_d = load_extend(dbus.dbus_rdata, mem_pipe_alu_result[1:0],
                                             mem_pipe_mem_funct3);
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (wb_pipe_flush || mem_pipe_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (dbus.dbus_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wb_d       = wb_q;
        wb_valid_d = wb_valid_q;
        if (mem_pipe_ready) begin
            wb_valid_d     = 1'b1;
            wb_d.pc          = mem_pipe_pc;
            wb_d.instruction = mem_pipe_instruction;
            wb_d.rd_write    = mem_pipe_rd_write;
            wb_d.rd_addr     = mem_pipe_rd_addr;
            wb_d.rd_data     = mem_pipe_mem_read ? load_buf_q : mem_pipe_alu_result;
            wb_d.csr_write   = mem_pipe_csr_write;
            wb_d.csr_set     = mem_pipe_csr_set;
            wb_d.csr_clear   = mem_pipe_csr_clear;
            wb_d.csr_read    = mem_pipe_csr_read;
            wb_d.csr_info    = mem_pipe_csr_info;
            wb_d.csr_addr    = mem_pipe_csr_addr;
        end else if (wb_pipe_flush || wb_pipe_ready) begin
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= S_IDLE;
            load_buf_q <= '0;
            wb_valid_q <= 1'b0;
            wb_q       <= '0;
        end else begin
            state_q    <= state_d;
            load_buf_q <= load_buf_d;
            wb_valid_q <= wb_valid_d;
            wb_q       <= wb_d;
        end
    end

    assign wb_pipe_valid       = wb_valid_q;
    assign wb_pipe_pc          = wb_q.pc;
    assign wb_pipe_instruction = wb_q.instruction;
    assign wb_pipe_rd_write    = wb_q.rd_write;
    assign wb_pipe_rd_addr     = wb_q.rd_addr;
    assign wb_pipe_rd_data     = wb_q.rd_data;
    assign wb_pipe_csr_write   = wb_q.csr_write;
    assign wb_pipe_csr_set     = wb_q.csr_set;
    assign wb_pipe_csr_clear   = wb_q.csr_clear;
    assign wb_pipe_csr_read    = wb_q.csr_read;
    assign wb_pipe_csr_info    = wb_q.csr_info;
    assign wb_pipe_csr_addr    = wb_q.csr_addr;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected MEM->WB entries
// and expected bus requests; two monitors compare whenever the DUT presents
// a WB entry or a bus request.
module tb_mem_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rd_write;
        logic [4:0]  rd_addr;
        logic [31:0] alu;
        logic        mem_read;
        logic        mem_write;
        logic [2:0]  f3;
        logic [31:0] sdata;
        logic [3:0]  csr_flags;
        logic [31:0] csr_info;
        logic [11:0] csr_addr;
    } ent_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rd_write;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic [3:0]  csr_flags;
        logic [31:0] csr_info;
        logic [11:0] csr_addr;
    } wb_exp_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_exp_t;

    logic        clk;
    logic        rst_b;
    logic        mem_pipe_ready, mem_pipe_flush, mem_pipe_valid;
    logic [31:0] mem_pipe_pc, mem_pipe_instruction, mem_pipe_alu_result, mem_pipe_store_data;
    logic        mem_pipe_rd_write, mem_pipe_mem_read, mem_pipe_mem_write;
    logic [4:0]  mem_pipe_rd_addr;
    logic [2:0]  mem_pipe_mem_funct3;
    logic        mem_pipe_csr_write, mem_pipe_csr_set, mem_pipe_csr_clear, mem_pipe_csr_read;
    logic [31:0] mem_pipe_csr_info;
    logic [11:0] mem_pipe_csr_addr;
    logic        wb_pipe_ready, wb_pipe_flush, wb_pipe_valid;
    logic [31:0] wb_pipe_pc, wb_pipe_instruction, wb_pipe_rd_data, wb_pipe_csr_info;
    logic        wb_pipe_rd_write;
    logic [4:0]  wb_pipe_rd_addr;
    logic        wb_pipe_csr_write, wb_pipe_csr_set, wb_pipe_csr_clear, wb_pipe_csr_read;
    logic [11:0] wb_pipe_csr_addr;

    mem_stage_if #(.XLEN(32)) dbus_if ();

    mem_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk                 (clk),
        .rst_b               (rst_b),
        .mem_pipe_ready      (mem_pipe_ready),
        .mem_pipe_flush      (mem_pipe_flush),
        .mem_pipe_valid      (mem_pipe_valid),
        .mem_pipe_pc         (mem_pipe_pc),
        .mem_pipe_instruction(mem_pipe_instruction),
        .mem_pipe_rd_write   (mem_pipe_rd_write),
        .mem_pipe_rd_addr    (mem_pipe_rd_addr),
        .mem_pipe_alu_result (mem_pipe_alu_result),
        .mem_pipe_mem_read   (mem_pipe_mem_read),
        .mem_pipe_mem_write  (mem_pipe_mem_write),
        .mem_pipe_mem_funct3 (mem_pipe_mem_funct3),
        .mem_pipe_store_data (mem_pipe_store_data),
        .mem_pipe_csr_write  (mem_pipe_csr_write),
        .mem_pipe_csr_set    (mem_pipe_csr_set),
        .mem_pipe_csr_clear  (mem_pipe_csr_clear),
        .mem_pipe_csr_read   (mem_pipe_csr_read),
        .mem_pipe_csr_info   (mem_pipe_csr_info),
        .mem_pipe_csr_addr   (mem_pipe_csr_addr),
        .dbus                (dbus_if.master),
        .wb_pipe_ready       (wb_pipe_ready),
        .wb_pipe_flush       (wb_pipe_flush),
        .wb_pipe_valid       (wb_pipe_valid),
        .wb_pipe_pc          (wb_pipe_pc),
        .wb_pipe_instruction (wb_pipe_instruction),
        .wb_pipe_rd_write    (wb_pipe_rd_write),
        .wb_pipe_rd_addr     (wb_pipe_rd_addr),
        .wb_pipe_rd_data     (wb_pipe_rd_data),
        .wb_pipe_csr_write   (wb_pipe_csr_write),
        .wb_pipe_csr_set     (wb_pipe_csr_set),
        .wb_pipe_csr_clear   (wb_pipe_csr_clear),
        .wb_pipe_csr_read    (wb_pipe_csr_read),
        .wb_pipe_csr_info    (wb_pipe_csr_info),
        .wb_pipe_csr_addr    (wb_pipe_csr_addr)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    wb_exp_t  wb_q[$];
    bus_exp_t bus_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic ent_t alu_ent(input logic [31:0] pc, input logic [31:0] alu,
                                     input logic [4:0] rd);
        ent_t e;
        e = '0;
        e.pc = pc; e.instr = pc ^ 32'h0000_0033; e.rd_write = 1'b1; e.rd_addr = rd;
        e.alu = alu; e.csr_flags = pc[5:2]; e.csr_info = ~pc; e.csr_addr = pc[13:2];
        return e;
    endfunction

    function automatic ent_t mem_ent(input logic [31:0] pc, input logic [31:0] addr,
                                     input logic rd_, input logic wr,
                                     input logic [2:0] f3, input logic [31:0] sdata);
        ent_t e;
        e = alu_ent(pc, addr, 5'd7);
        e.rd_write = rd_; e.mem_read = rd_; e.mem_write = wr; e.f3 = f3; e.sdata = sdata;
        e.csr_flags = 4'b0000;
        return e;
    endfunction

    task automatic drive(input ent_t e);
        mem_pipe_pc = e.pc; mem_pipe_instruction = e.instr;
        mem_pipe_rd_write = e.rd_write; mem_pipe_rd_addr = e.rd_addr;
        mem_pipe_alu_result = e.alu; mem_pipe_mem_read = e.mem_read;
        mem_pipe_mem_write = e.mem_write; mem_pipe_mem_funct3 = e.f3;
        mem_pipe_store_data = e.sdata;
        {mem_pipe_csr_write, mem_pipe_csr_set, mem_pipe_csr_clear, mem_pipe_csr_read} = e.csr_flags;
        mem_pipe_csr_info = e.csr_info; mem_pipe_csr_addr = e.csr_addr;
        mem_pipe_valid = 1'b1;
    endtask

    function automatic wb_exp_t to_wb(input ent_t e, input logic [31:0] rd);
        return '{pc: e.pc, instr: e.instr, rd_write: e.rd_write, rd_addr: e.rd_addr,
                 rd_data: rd, csr_flags: e.csr_flags, csr_info: e.csr_info,
                 csr_addr: e.csr_addr};
    endfunction

    // Called at a negedge; returns at the negedge following retirement.
    task automatic issue(input ent_t e, input int rdy_dly, input int rv_dly,
                         input logic [31:0] rdata, input logic [31:0] exp_rd,
                         input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                         input logic [3:0] exp_wstrb, input int exp_lat, input string name);
        int stall, since, done_at;
        bit acc;
        stall = 0; since = 0; acc = 0; done_at = -1;
        drive(e);
        wb_q.push_back(to_wb(e, exp_rd));
        if (e.mem_read || e.mem_write)
            bus_q.push_back('{write: e.mem_write, addr: exp_addr, wdata: exp_wdata, wstrb: exp_wstrb});
        for (int c = 0; c < 100 && done_at < 0; c++) begin
            #1;
            dbus_if.dbus_ready = 1'b0;
            dbus_if.dbus_rvalid = 1'b0;
            if (acc) begin
                since++;
                if (since == rv_dly) begin
                    dbus_if.dbus_rvalid = 1'b1;
                    dbus_if.dbus_rdata = rdata;
                end
            end else if (dbus_if.dbus_req) begin
                if (stall == rdy_dly) dbus_if.dbus_ready = 1'b1;
                else stall++;
            end
            #1;
            if (dbus_if.dbus_req && dbus_if.dbus_ready) acc = 1;
            if (mem_pipe_ready) done_at = c;
            @(negedge clk);
        end
        chk({name, "_latency"}, done_at, exp_lat);
        mem_pipe_valid = 1'b0;
        dbus_if.dbus_ready = 1'b0;
        dbus_if.dbus_rvalid = 1'b0;
    endtask

    // WB-side monitor: compares the presented entry every cycle it is valid
    // (so stalls also check stability) and pops it when WB accepts.
    initial begin
        wb_exp_t act;
        forever begin
            @(negedge clk); #3;
            if (rst_b && wb_pipe_valid) begin
                act = '{pc: wb_pipe_pc, instr: wb_pipe_instruction, rd_write: wb_pipe_rd_write,
                        rd_addr: wb_pipe_rd_addr, rd_data: wb_pipe_rd_data,
                        csr_flags: {wb_pipe_csr_write, wb_pipe_csr_set, wb_pipe_csr_clear,
                                    wb_pipe_csr_read},
                        csr_info: wb_pipe_csr_info, csr_addr: wb_pipe_csr_addr};
                if (wb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wb_unexpected: got entry %h expected none", act);
                end else begin
                    chk("wb_entry", act, wb_q[0]);
                    if (wb_pipe_ready) void'(wb_q.pop_front());
                end
            end
        end
    end

    // Bus monitor: request fields must match (and hold) until accepted.
    initial begin
        bus_exp_t act;
        forever begin
            @(negedge clk); #3;
            if (rst_b && dbus_if.dbus_req) begin
                act = '{write: dbus_if.dbus_write, addr: dbus_if.dbus_addr,
                        wdata: dbus_if.dbus_wdata, wstrb: dbus_if.dbus_wstrb};
                if (bus_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL bus_unexpected: got req %h expected none", act);
                end else begin
                    if (!bus_q[0].write) begin
                        act.wdata = '0; act.wstrb = '0;
                    end
                    chk("bus_req", act, bus_q[0]);
                    if (dbus_if.dbus_ready) void'(bus_q.pop_front());
                end
            end
        end
    end

    initial begin
        int c0;
        ent_t e;
        rst_b = 1'b0;
        mem_pipe_valid = 1'b0;
        drive('0);
        mem_pipe_valid = 1'b0;
        wb_pipe_ready = 1'b1;
        wb_pipe_flush = 1'b0;
        dbus_if.dbus_ready = 1'b0;
        dbus_if.dbus_rvalid = 1'b0;
        dbus_if.dbus_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_wb_valid", wb_pipe_valid, 1'b0);
        chk("rst_wb_data", {wb_pipe_pc, wb_pipe_rd_data, wb_pipe_csr_info}, 96'h0);
        chk("rst_dbus_req", dbus_if.dbus_req, 1'b0);
        rst_b = 1'b1;
        @(negedge clk);

        // Back-to-back ALU ops: one retirement per cycle.
        c0 = cyc;
        issue(alu_ent(32'h100, 32'h1111_0001, 5'd1), 0, 0, 0, 32'h1111_0001, 0, 0, 0, 0, "alu0");
        issue(alu_ent(32'h104, 32'h2222_0002, 5'd2), 0, 0, 0, 32'h2222_0002, 0, 0, 0, 0, "alu1");
        issue(alu_ent(32'h108, 32'h3333_0003, 5'd3), 0, 0, 0, 32'h3333_0003, 0, 0, 0, 0, "alu2");
        issue(alu_ent(32'h10C, 32'h4444_0004, 5'd4), 0, 0, 0, 32'h4444_0004, 0, 0, 0, 0, "alu3");
        chk("b2b_cycles", cyc - c0, 4);

        // Loads with immediate ready and rvalid one cycle after acceptance.
        issue(mem_ent(32'h200, 32'h1003, 1, 0, 3'b000, 0), 0, 1, 32'h80AABBCC, 32'hFFFFFF80,
              32'h1000, 0, 0, 2, "lb");
        issue(mem_ent(32'h204, 32'h1003, 1, 0, 3'b100, 0), 0, 1, 32'h80AABBCC, 32'h00000080,
              32'h1000, 0, 0, 2, "lbu");
        issue(mem_ent(32'h208, 32'h1002, 1, 0, 3'b001, 0), 0, 1, 32'h80AABBCC, 32'hFFFF80AA,
              32'h1000, 0, 0, 2, "lh");
        issue(mem_ent(32'h20C, 32'h1002, 1, 0, 3'b101, 0), 0, 1, 32'h80AABBCC, 32'h000080AA,
              32'h1000, 0, 0, 2, "lhu");

        // Stores: stalled SH, then lane/strobe variants including truncation.
        issue(mem_ent(32'h300, 32'h2002, 0, 1, 3'b001, 32'h1234ABCD), 3, 0, 0, 32'h2002,
              32'h2000, 32'hABCDABCD, 4'b1100, 3, "sh_stall");
        issue(mem_ent(32'h304, 32'h4001, 0, 1, 3'b000, 32'h000000A5), 0, 0, 0, 32'h4001,
              32'h4000, 32'hA5A5A5A5, 4'b0010, 0, "sb");
        issue(mem_ent(32'h308, 32'h5000, 0, 1, 3'b010, 32'h0BADF00D), 0, 0, 0, 32'h5000,
              32'h5000, 32'h0BADF00D, 4'b1111, 0, "sw");
        issue(mem_ent(32'h30C, 32'h6003, 0, 1, 3'b001, 32'h0000BEEF), 0, 0, 0, 32'h6003,
              32'h6000, 32'hBEEFBEEF, 4'b1000, 0, "sh_trunc");

        // Late LW, then WB stalls two cycles holding the loaded value.
        @(negedge clk);
        wb_pipe_ready = 1'b0;
        issue(mem_ent(32'h400, 32'h3000, 1, 0, 3'b010, 0), 0, 4, 32'hCAFEF00D, 32'hCAFEF00D,
              32'h3000, 0, 0, 5, "lw_late");
        repeat (2) @(negedge clk);
        wb_pipe_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Flush while the load response is outstanding; stale data must vanish.
        e = mem_ent(32'h500, 32'h7100, 1, 0, 3'b010, 0);
        drive(e);
        bus_q.push_back('{write: 1'b0, addr: 32'h7100, wdata: 0, wstrb: 0});
        #1 dbus_if.dbus_ready = dbus_if.dbus_req;
        @(negedge clk);
        dbus_if.dbus_ready = 1'b0;
        wb_pipe_flush = 1'b1;
        mem_pipe_valid = 1'b0;
        #2 chk("flush_fwd", mem_pipe_flush, 1'b1);
        @(negedge clk);
        wb_pipe_flush = 1'b0;
        dbus_if.dbus_rvalid = 1'b1;
        dbus_if.dbus_rdata = 32'hDEADBEEF;
        @(negedge clk);
        dbus_if.dbus_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        issue(mem_ent(32'h504, 32'h7000, 1, 0, 3'b010, 0), 0, 2, 32'h11223344, 32'h11223344,
              32'h7000, 0, 0, 3, "lw_after_flush");
        repeat (2) @(negedge clk);

        // Asynchronous reset during WAIT_RSP, then a stray response.
        e = mem_ent(32'h600, 32'h9000, 1, 0, 3'b010, 0);
        drive(e);
        bus_q.push_back('{write: 1'b0, addr: 32'h9000, wdata: 0, wstrb: 0});
        #1 dbus_if.dbus_ready = dbus_if.dbus_req;
        @(negedge clk);
        dbus_if.dbus_ready = 1'b0;
        #2;
        rst_b = 1'b0;
        mem_pipe_valid = 1'b0;
        #1;
        chk("arst_wb_valid", wb_pipe_valid, 1'b0);
        chk("arst_wb_data", {wb_pipe_pc, wb_pipe_rd_data, wb_pipe_instruction}, 96'h0);
        chk("arst_dbus_req", dbus_if.dbus_req, 1'b0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        dbus_if.dbus_rvalid = 1'b1;
        dbus_if.dbus_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        dbus_if.dbus_rvalid = 1'b0;
        @(negedge clk);
        issue(alu_ent(32'h700, 32'h5555_AAAA, 5'd9), 0, 0, 0, 32'h5555_AAAA, 0, 0, 0, 0, "alu_post");
        issue(mem_ent(32'h704, 32'h8000, 1, 0, 3'b000, 0), 0, 1, 32'h0000007F, 32'h0000007F,
              32'h8000, 0, 0, 2, "lb_post");
        repeat (3) @(negedge clk);

        chk("wb_queue_empty", wb_q.size(), 0);
        chk("bus_queue_empty", bus_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
